stopwatch_lap_ctrl: RTL and testbench

STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

---
 rtl/stopwatch_lap_ctrl_if.sv | 34 +++
 rtl/stopwatch_lap_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_ctrl_if.sv
// stopwatch_lap_ctrl_if: control, timer and display signals of the stopwatch lap controller.
// master = stopwatch environment (drives buttons/time), slave = controller.
interface stopwatch_lap_ctrl_if #(
  parameter int unsigned TIME_W    = 24,
  parameter int unsigned LAP_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(LAP_DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(LAP_DEPTH);

  logic              clk_en;
  logic              start_pause_btn;
  logic              lap_btn;
  logic              reset_btn;
  logic [TIME_W-1:0] time_in;
  logic              counting;
  logic              reset_timer;
  logic [TIME_W-1:0] display_time;
  logic [CNT_W-1:0]  lap_count;
  logic [IDX_W-1:0]  lap_index;
  logic              lap_overflow;
  logic [2:0]        state_out;

  modport master (
    output clk_en, start_pause_btn, lap_btn, reset_btn, time_in,
    input  counting, reset_timer, display_time, lap_count, lap_index,
           lap_overflow, state_out
  );

  modport slave (
    input  clk_en, start_pause_btn, lap_btn, reset_btn, time_in,
    output counting, reset_timer, display_time, lap_count, lap_index,
           lap_overflow, state_out
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: start/pause/lap/reset control for a stopwatch with a lap buffer.
// Optional macro STOPWATCH_LAP_RECALL_EN adds the RECALL state for reading laps back in PAUSE.
module stopwatch_lap_ctrl #(
  parameter int unsigned TIME_W     = 24,
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned HOLD_TICKS = 2000
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_lap_ctrl_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(LAP_DEPTH) + 1;
  localparam int unsigned IDX_W  = $clog2(LAP_DEPTH);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_SPLIT  = 3'd2;
  localparam logic [2:0] ST_PAUSE  = 3'd3;
  localparam logic [2:0] ST_RECALL = 3'd4;

  logic [2:0]                      r_state;
  logic [2:0]                      w_state_nxt;
  logic                            r_sp_prev;
  logic                            r_lap_prev;
  logic                            w_rb_low;
  logic                            w_sp_ev;
  logic                            w_lap_ev;
  logic                            w_capture;
  logic                            w_store;
  logic [HOLD_W-1:0]               r_hold;
  logic [HOLD_W-1:0]               w_hold_nxt;
  logic [TIME_W-1:0]               r_split;
  logic [TIME_W-1:0]               w_split_nxt;
  logic [LAP_DEPTH-1:0][TIME_W-1:0] r_buf;
  logic [CNT_W-1:0]                r_lap_count;
  logic [CNT_W-1:0]                w_lap_count_nxt;
  logic [IDX_W-1:0]                r_lap_index;
  logic [IDX_W-1:0]                w_lap_index_nxt;
  logic                            r_overflow;
  logic                            w_overflow_nxt;
  logic                            r_counting;
  logic                            w_counting_nxt;
  logic                            r_reset_timer;
  logic                            w_reset_timer_nxt;
  logic [TIME_W-1:0]               r_display;
  logic [TIME_W-1:0]               w_display_nxt;

  // Prioritised button events: reset level masks everything, start/pause masks lap.
  assign w_rb_low = ~bus.reset_btn;
  assign w_sp_ev  = ~w_rb_low & r_sp_prev & ~bus.start_pause_btn;
  assign w_lap_ev = ~w_rb_low & ~w_sp_ev & r_lap_prev & ~bus.lap_btn;

  // State register; advances only on clk_en cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (bus.clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (w_rb_low) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sp_ev) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_sp_ev)       w_state_nxt = ST_PAUSE;
          else if (w_lap_ev) w_state_nxt = ST_SPLIT;
        end
        ST_SPLIT: begin
          if (w_sp_ev)                     w_state_nxt = ST_PAUSE;
          else if (w_lap_ev)               w_state_nxt = ST_SPLIT;
          else if (r_hold == HOLD_W'(1))   w_state_nxt = ST_RUN;
        end
        ST_PAUSE: begin
          if (w_sp_ev) w_state_nxt = ST_RUN;
`ifdef STOPWATCH_LAP_RECALL_EN
          else if (w_lap_ev && (r_lap_count != '0)) w_state_nxt = ST_RECALL;
`endif
        end
`ifdef STOPWATCH_LAP_RECALL_EN
        ST_RECALL: begin
          if (w_sp_ev) w_state_nxt = ST_PAUSE;
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the datapath registers and the registered outputs.
  always_comb begin
    w_capture         = 1'b0;
    w_store           = 1'b0;
    w_hold_nxt        = r_hold;
    w_split_nxt       = r_split;
    w_lap_count_nxt   = r_lap_count;
    w_lap_index_nxt   = r_lap_index;
    w_overflow_nxt    = r_overflow;
    w_reset_timer_nxt = w_rb_low;
    w_counting_nxt    = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_SPLIT);
    w_display_nxt     = bus.time_in;

    if (w_rb_low) begin
      w_hold_nxt      = '0;
      w_lap_count_nxt = '0;
      w_lap_index_nxt = '0;
      w_overflow_nxt  = 1'b0;
    end else begin
      w_capture = w_lap_ev && ((r_state == ST_RUN) || (r_state == ST_SPLIT));
      w_store   = w_capture && (r_lap_count < CNT_W'(LAP_DEPTH));
      if (w_capture) begin
        w_split_nxt = bus.time_in;
        w_hold_nxt  = HOLD_W'(HOLD_TICKS);
        if (w_store) w_lap_count_nxt = r_lap_count + CNT_W'(1);
        else         w_overflow_nxt  = 1'b1;
      end else if (r_state == ST_SPLIT) begin
        w_hold_nxt = (w_sp_ev || (r_hold == '0)) ? '0 : r_hold - HOLD_W'(1);
      end
`ifdef STOPWATCH_LAP_RECALL_EN
      if ((r_state == ST_RECALL) && w_lap_ev) begin
        w_lap_index_nxt = ((CNT_W'(r_lap_index) + CNT_W'(1)) == r_lap_count) ?
                          '0 : r_lap_index + IDX_W'(1);
      end
`endif
      if (w_state_nxt != ST_RECALL) w_lap_index_nxt = '0;
    end

    case (w_state_nxt)
      ST_SPLIT:  w_display_nxt = w_split_nxt;
`ifdef STOPWATCH_LAP_RECALL_EN
      ST_RECALL: w_display_nxt = r_buf[w_lap_index_nxt];
`endif
      default:   w_display_nxt = bus.time_in;
    endcase
  end

  // Button history, hold counter, split register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp_prev     <= 1'b1;
      r_lap_prev    <= 1'b1;
      r_hold        <= '0;
      r_split       <= '0;
      r_lap_count   <= '0;
      r_lap_index   <= '0;
      r_overflow    <= 1'b0;
      r_counting    <= 1'b0;
      r_reset_timer <= 1'b1;
      r_display     <= '0;
    end else if (bus.clk_en) begin
      r_sp_prev     <= bus.start_pause_btn;
      r_lap_prev    <= bus.lap_btn;
      r_hold        <= w_hold_nxt;
      r_split       <= w_split_nxt;
      r_lap_count   <= w_lap_count_nxt;
      r_lap_index   <= w_lap_index_nxt;
      r_overflow    <= w_overflow_nxt;
      r_counting    <= w_counting_nxt;
      r_reset_timer <= w_reset_timer_nxt;
      r_display     <= w_display_nxt;
    end
  end

  // Lap buffer; only cleared by the hard reset, rewritten from entry 0 after a reset_btn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
    end else if (bus.clk_en && w_store) begin
      r_buf[r_lap_count[IDX_W-1:0]] <= bus.time_in;
    end
  end

`ifndef STOPWATCH_LAP_RECALL_EN
  // Without read-back the buffer is kept but has no reader.
  logic w_unused_buf;
  assign w_unused_buf = ^r_buf;
`endif

  assign bus.counting     = r_counting;
  assign bus.reset_timer  = r_reset_timer;
  assign bus.display_time = r_display;
  assign bus.lap_count    = r_lap_count;
  assign bus.lap_index    = r_lap_index;
  assign bus.lap_overflow = r_overflow;
  assign bus.state_out    = r_state;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: directed and randomized checks of stopwatch_lap_ctrl against a
// behavioural model; honours STOPWATCH_LAP_RECALL_EN the same way as the design.
module tb_stopwatch_lap_ctrl;
  localparam int unsigned TIME_W     = 24;
  localparam int unsigned LAP_DEPTH  = 4;
  localparam int unsigned HOLD_TICKS = 2000;
`ifdef STOPWATCH_LAP_RECALL_EN
  localparam bit RECALL_EN = 1'b1;
`else
  localparam bit RECALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  stopwatch_lap_ctrl_if #(.TIME_W(TIME_W), .LAP_DEPTH(LAP_DEPTH)) bus ();

  stopwatch_lap_ctrl #(
    .TIME_W(TIME_W), .LAP_DEPTH(LAP_DEPTH), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  // Behavioural model state (state numbers are the externally visible codes).
  int                m_state;
  int                m_hold;
  int                m_count;
  int                m_idx;
  bit                m_sp_prev;
  bit                m_lap_prev;
  bit                m_ovf;
  bit                m_rt;
  logic [TIME_W-1:0] m_split;
  logic [TIME_W-1:0] m_disp;
  logic [TIME_W-1:0] m_buf [LAP_DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_hold = 0; m_count = 0; m_idx = 0;
    m_sp_prev = 1'b1; m_lap_prev = 1'b1; m_ovf = 1'b0; m_rt = 1'b1;
    m_split = '0; m_disp = '0;
    for (int i = 0; i < LAP_DEPTH; i++) m_buf[i] = '0;
  endfunction

  function automatic void model_step();
    bit sp_ev, lap_ev;
    sp_ev  = m_sp_prev && !bus.start_pause_btn;
    lap_ev = m_lap_prev && !bus.lap_btn;
    m_sp_prev  = bus.start_pause_btn;
    m_lap_prev = bus.lap_btn;
    if (!bus.reset_btn) begin
      m_state = 0; m_count = 0; m_idx = 0; m_ovf = 1'b0; m_hold = 0; m_rt = 1'b1;
    end else begin
      m_rt = 1'b0;
      if (sp_ev) begin
        case (m_state)
          0, 3:    m_state = 1;
          1, 2, 4: m_state = 3;
          default: m_state = 0;
        endcase
        m_idx = 0; m_hold = 0;
      end else if (lap_ev) begin
        if (m_state == 1 || m_state == 2) begin
          m_split = bus.time_in;
          if (m_count < LAP_DEPTH) begin
            m_buf[m_count] = bus.time_in;
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
          m_hold  = HOLD_TICKS;
          m_state = 2;
        end else if (m_state == 3 && RECALL_EN && m_count > 0) begin
          m_state = 4; m_idx = 0;
        end else if (m_state == 4) begin
          m_idx = (m_idx + 1) % m_count;
        end
      end else if (m_state == 2) begin
        m_hold--;
        if (m_hold == 0) m_state = 1;
      end
    end
    case (m_state)
      2:       m_disp = m_split;
      4:       m_disp = m_buf[m_idx];
      default: m_disp = bus.time_in;
    endcase
  endfunction

  // Model follows the DUT's reset and clk_en sampling.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else if (bus.clk_en) model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state_out",    32'(bus.state_out),    32'(m_state));
      chk("counting",     32'(bus.counting),     32'(m_state == 1 || m_state == 2));
      chk("reset_timer",  32'(bus.reset_timer),  32'(m_rt));
      chk("display_time", 32'(bus.display_time), 32'(m_disp));
      chk("lap_count",    32'(bus.lap_count),    32'(m_count));
      chk("lap_index",    32'(bus.lap_index),    32'(m_idx));
      chk("lap_overflow", 32'(bus.lap_overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    bus.clk_en = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic hit(input bit sp, input bit lap, input bit rb);
    bus.start_pause_btn = ~sp;
    bus.lap_btn         = ~lap;
    bus.reset_btn       = ~rb;
    tick();
  endtask

  task automatic rel();
    bus.start_pause_btn = 1'b1;
    bus.lap_btn         = 1'b1;
    bus.reset_btn       = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},    32'(bus.state_out),    32'd0);
    chk({tag, "_counting"}, 32'(bus.counting),     32'd0);
    chk({tag, "_rt"},       32'(bus.reset_timer),  32'd1);
    chk({tag, "_display"},  32'(bus.display_time), 32'd0);
    chk({tag, "_count"},    32'(bus.lap_count),    32'd0);
    chk({tag, "_index"},    32'(bus.lap_index),    32'd0);
    chk({tag, "_ovf"},      32'(bus.lap_overflow), 32'd0);
  endtask

  initial begin
    logic [TIME_W-1:0] caps [4];
    rst = 1'b1;
    bus.clk_en = 1'b0;
    bus.start_pause_btn = 1'b1;
    bus.lap_btn = 1'b1;
    bus.reset_btn = 1'b1;
    bus.time_in = 24'h000042;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk_reset_vals("por");
    rst = 1'b0;
    tick();
    chk("rt_release", 32'(bus.reset_timer), 32'd0);

    // Start counting.
    hit(1, 0, 0);
    chk("start_state", 32'(bus.state_out), 32'd1);
    chk("start_counting", 32'(bus.counting), 32'd1);
    rel();

    // Split hold for HOLD_TICKS ticks while time advances.
    bus.time_in = 24'h001234;
    hit(0, 1, 0);
    chk("lap1_count", 32'(bus.lap_count), 32'd1);
    chk("lap1_display", 32'(bus.display_time), 32'h001234);
    chk("lap1_state", 32'(bus.state_out), 32'd2);
    rel();
    for (int i = 0; i < HOLD_TICKS - 2; i++) begin
      bus.time_in = bus.time_in + 24'd1;
      tick();
    end
    chk("hold_last_display", 32'(bus.display_time), 32'h001234);
    chk("hold_last_state", 32'(bus.state_out), 32'd2);
    bus.time_in = bus.time_in + 24'd1;
    tick();
    chk("hold_exit_state", 32'(bus.state_out), 32'd1);
    chk("hold_exit_display", 32'(bus.display_time), 32'(24'h001234 + 24'(HOLD_TICKS - 1)));

    // Fill the buffer, then overflow.
    caps[0] = 24'h001234;
    for (int i = 1; i <= 4; i++) begin
      bus.time_in = 24'(i * 256);
      if (i < 4) caps[i] = bus.time_in;
      hit(0, 1, 0);
      rel();
    end
    chk("ovf_count", 32'(bus.lap_count), 32'd4);
    chk("ovf_flag", 32'(bus.lap_overflow), 32'd1);
    chk("ovf_split_display", 32'(bus.display_time), 32'h000400);
    hit(1, 0, 0);
    chk("pause_state", 32'(bus.state_out), 32'd3);
    chk("pause_counting", 32'(bus.counting), 32'd0);
    rel();
    for (int i = 0; i < 4; i++) begin
      bus.time_in = 24'h009000 + 24'(i);
      hit(0, 1, 0);
      chk("buf_idx", 32'(bus.lap_index), RECALL_EN ? 32'(i) : 32'd0);
      chk("buf_display", 32'(bus.display_time), RECALL_EN ? 32'(caps[i]) : 32'(bus.time_in));
      rel();
    end

    // Clear with reset_btn, then three laps and recall cycling.
    hit(0, 0, 1);
    chk("rbtn_state", 32'(bus.state_out), 32'd0);
    chk("rbtn_rt", 32'(bus.reset_timer), 32'd1);
    chk("rbtn_count", 32'(bus.lap_count), 32'd0);
    chk("rbtn_ovf", 32'(bus.lap_overflow), 32'd0);
    rel();
    chk("rbtn_rt_release", 32'(bus.reset_timer), 32'd0);
    hit(1, 0, 0); rel();
    for (int i = 1; i <= 3; i++) begin
      bus.time_in = 24'(i * 24'h111);
      hit(0, 1, 0); rel();
    end
    hit(1, 0, 0); rel();
    for (int i = 0; i < 4; i++) begin
      bus.time_in = 24'h00AB00 + 24'(i);
      hit(0, 1, 0);
      chk("recall_idx", 32'(bus.lap_index), RECALL_EN ? 32'(i % 3) : 32'd0);
      chk("recall_display", 32'(bus.display_time),
          RECALL_EN ? 32'(((i % 3) + 1) * 32'h111) : 32'(bus.time_in));
      chk("recall_counting", 32'(bus.counting), 32'd0);
      rel();
    end

    // Simultaneous events.
    hit(0, 0, 1); rel();
    hit(1, 0, 0); rel();
    hit(1, 1, 0);
    chk("both_state", 32'(bus.state_out), 32'd3);
    chk("both_count", 32'(bus.lap_count), 32'd0);
    rel();
    hit(1, 1, 1);
    chk("all_state", 32'(bus.state_out), 32'd0);
    chk("all_rt", 32'(bus.reset_timer), 32'd1);
    rel();

    // Asynchronous reset in the middle of SPLIT.
    hit(1, 0, 0); rel();
    bus.time_in = 24'h005555;
    hit(0, 1, 0); rel();
    chk("pre_rst_state", 32'(bus.state_out), 32'd2);
    #3 rst = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 30000; i++) begin
      bus.clk_en          = ($urandom_range(0, 2) == 0);
      bus.start_pause_btn = ($urandom_range(0, 24) != 0);
      bus.lap_btn         = ($urandom_range(0, 14) != 0);
      bus.reset_btn       = ($urandom_range(0, 499) != 0);
      bus.time_in         = TIME_W'($urandom);
      if ($urandom_range(0, 4999) == 0) begin
        #3 rst = 1'b1;
        #2 chk("rnd_async_state", 32'(bus.state_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    bus.clk_en = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
